// File: rtl/corr_decoder.sv
// rtl/corr_decoder.sv - serial pattern correlator with mismatch tolerance and hit counter
//
// Purpose:
//   A LEN-bit reference pattern is loaded serially (MSB first), then a serial
//   signal is compared against it. On every RUN cycle the sliding window
//   (including the bit sampled on that edge) is XORed with the pattern, and the
//   mismatches are counted. A match is flagged when the window is full and the
//   mismatch count is within MAXERR. Match cycles are counted in a saturating
//   counter.
//
// Ports:
//   clk    in   1         clock, rising edge
//   clr    in   1         synchronous active-high reset, wins over load
//   load   in   1         start programming a new pattern (IDLE or RUN)
//   prgm   in   1         serial pattern bit, sampled in PROG only
//   sig    in   1         serial signal bit, sampled in RUN only
//   out    out  1         registered match flag
//   ready  out  1         registered, high while in RUN
//   errs   out  CW        registered mismatch count of current window (0 until full)
//   hits   out  CNTW      registered saturating count of match cycles

module corr_decoder #(
  parameter int LEN    = 256,
  parameter int MAXERR = 0,
  parameter int CNTW   = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       prgm,
  input  logic                       sig,
  output logic                       out,
  output logic                       ready,
  output logic [$clog2(LEN+1)-1:0]   errs,
  output logic [CNTW-1:0]            hits
);

  localparam int CW = $clog2(LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROG = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [CW-1:0]   LEN_C    = CW'(LEN);
  localparam logic [CW-1:0]   LAST_BIT = CW'(LEN - 1);
  // A tolerance larger than LEN always matches a full window; clamp so it fits CW.
  localparam int              MAXERR_SAT = (MAXERR > LEN) ? LEN : MAXERR;
  localparam logic [CW-1:0]   MAXERR_C = CW'(MAXERR_SAT);
  localparam logic [CNTW-1:0] HITS_MAX = '1;

  logic [1:0]       r_state;
  logic [LEN-1:0]   r_pattern;
  // Only the LEN-1 most recent signal bits are kept; the incoming sig bit
  // completes the window combinationally.
  logic [LEN-2:0]   r_hist;
  logic [CW-1:0]    r_fill;
  logic [CW-1:0]    r_bitcnt;
  logic             r_out;
  logic             r_ready;
  logic [CW-1:0]    r_errs;
  logic [CNTW-1:0]  r_hits;

  logic [LEN-1:0]   w_window;
  logic [LEN-1:0]   w_diff;
  logic [CW-1:0]    w_popcnt;
  logic [CW-1:0]    w_next_fill;
  logic             w_full;
  logic             w_match;

  assign w_window    = {r_hist, sig};
  assign w_diff      = r_pattern ^ w_window;
  assign w_next_fill = (r_fill == LEN_C) ? r_fill : (r_fill + CW'(1));
  assign w_full      = (w_next_fill == LEN_C);
  assign w_match     = w_full && (w_popcnt <= MAXERR_C);

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < LEN; i++) begin
      w_popcnt = w_popcnt + CW'(w_diff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_bitcnt  <= '0;
      r_out     <= 1'b0;
      r_ready   <= 1'b0;
      r_errs    <= '0;
      r_hits    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out  <= 1'b0;
          r_errs <= '0;
          if (load) begin
            r_state  <= S_PROG;
            r_bitcnt <= '0;
            r_hist   <= '0;
            r_fill   <= '0;
            r_hits   <= '0;
          end
        end

        S_PROG: begin
          // load is deliberately not looked at here: a running program
          // sequence can only be aborted by clr.
          r_out     <= 1'b0;
          r_errs    <= '0;
          r_pattern <= {r_pattern[LEN-2:0], prgm};
          if (r_bitcnt == LAST_BIT) begin
            r_state  <= S_RUN;
            r_ready  <= 1'b1;
            r_bitcnt <= '0;
          end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end

        S_RUN: begin
          if (load) begin
            // Reprogram request: sig is not shifted on this edge.
            r_state  <= S_PROG;
            r_ready  <= 1'b0;
            r_hist   <= '0;
            r_fill   <= '0;
            r_bitcnt <= '0;
            r_out    <= 1'b0;
            r_errs   <= '0;
            r_hits   <= '0;
          end else begin
            r_hist <= w_window[LEN-2:0];
            r_fill <= w_next_fill;
            r_out  <= w_match;
            r_errs <= w_full ? w_popcnt : '0;
            if (w_match && (r_hits != HITS_MAX)) begin
              r_hits <= r_hits + CNTW'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_out   <= 1'b0;
          r_errs  <= '0;
        end
      endcase
    end
  end

  assign out   = r_out;
  assign ready = r_ready;
  assign errs  = r_errs;
  assign hits  = r_hits;

endmodule
